// File: rtl/hpi_txn_engine_pkg.sv
// hpi_pkg: shared types for hpi_txn_engine: FSM state encoding, HPI register map
// and a helper that sizes the shared timing down-counter.
// Optional feature macro: HPI_RESET_SEQ_EN adds the chip-reset (RST) state.
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
`ifdef HPI_RESET_SEQ_EN
    ST_HOLD,
    ST_RST
`else
    ST_HOLD
`endif
  } hpi_state_e;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDR    = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  // Width needed to hold (largest cycle count - 1) in the shared down-counter.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hpi_txn_engine_if.sv
// hpi_txn_if: request/response handshake plus HPI pin bundle for hpi_txn_engine.
// slave = the engine, master = the fabric/pad side driving it.
interface hpi_txn_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              chip_rst_req;
  logic              busy;
  logic [1:0]        hpi_addr;
  logic              hpi_cs_n;
  logic              hpi_r_n;
  logic              hpi_w_n;
  logic [DATA_W-1:0] hpi_data_out;
  logic              hpi_data_oe;
  logic [DATA_W-1:0] hpi_data_in;
  logic              hpi_reset_n;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, chip_rst_req, hpi_data_in,
    output req_ready, rsp_valid, rsp_rdata, busy, hpi_addr, hpi_cs_n, hpi_r_n,
           hpi_w_n, hpi_data_out, hpi_data_oe, hpi_reset_n
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, chip_rst_req, hpi_data_in,
    input  req_ready, rsp_valid, rsp_rdata, busy, hpi_addr, hpi_cs_n, hpi_r_n,
           hpi_w_n, hpi_data_out, hpi_data_oe, hpi_reset_n
  );
endinterface

// File: rtl/hpi_txn_engine_cmd_fifo.sv
// hpi_cmd_fifo: synchronous request queue for hpi_txn_engine. Pointers carry one
// extra wrap bit so full and empty are told apart without an occupancy counter.
module hpi_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;
  T            mem_q [DEPTH];

  assign full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign push_ok  = push_i && !full_o;
  assign pop_ok   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write.
  // NOTE: the array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Pointer registers.
  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/hpi_txn_engine.sv
// hpi_txn_engine: queues fabric read/write requests and replays them on the OTG
// chip's HPI pins with programmable setup/strobe/hold timing.
// Optional feature macro: HPI_RESET_SEQ_EN (chip-reset sequencer, RST state).
module hpi_txn_engine
  import hpi_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RESET_CYC  = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  hpi_txn_if.slave   bus
);
  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, RESET_CYC);

`ifdef HPI_RESET_SEQ_EN
  localparam hpi_state_e       ST_RESET  = ST_RST;
  localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(RESET_CYC - 1);
`else
  localparam hpi_state_e       ST_RESET  = ST_IDLE;
  localparam logic [CNT_W-1:0] CNT_RESET = '0;
`endif

  typedef struct packed {
    logic              write;
    hpi_reg_e          addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              push_req, fifo_head, cur_q, cur_d;
  logic              fifo_full, fifo_empty, pop;
  hpi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              active, oe;

  assign push_req = '{write: bus.req_write, addr: hpi_reg_e'(bus.req_addr), wdata: bus.req_wdata};

  hpi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_cmd_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push_i  (bus.req_valid),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef HPI_RESET_SEQ_EN
  logic rst_pend_q, rst_pend_d;

  // Chip-reset request latch; consumed when the FSM enters RST.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_pend_q <= 1'b0;
    else                rst_pend_q <= rst_pend_d;
  end
`else
  logic unused_chip_rst_req;
  assign unused_chip_rst_req = bus.chip_rst_req;
`endif

  // Next-state, counter reload, pop and read-capture decisions.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    pop         = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
`ifdef HPI_RESET_SEQ_EN
    rst_pend_d  = rst_pend_q | bus.chip_rst_req;
`endif
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
`ifdef HPI_RESET_SEQ_EN
        if (rst_pend_q) begin
          state_d    = ST_RST;
          cnt_d      = CNT_W'(RESET_CYC - 1);
          rst_pend_d = 1'b0;
        end else
`endif
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = fifo_head;
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          if (!cur_q.write) begin
            rsp_valid_d = 1'b1;
            rdata_d     = bus.hpi_data_in;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
`ifdef HPI_RESET_SEQ_EN
      ST_RST: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, shared counter, in-flight request and read response registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= CNT_RESET;
      cur_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign active           = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign oe               = active && cur_q.write;
  assign bus.hpi_cs_n     = !active;
  assign bus.hpi_r_n      = !((state_q == ST_STROBE) && !cur_q.write);
  assign bus.hpi_w_n      = !((state_q == ST_STROBE) && cur_q.write);
  assign bus.hpi_data_oe  = oe;
  assign bus.hpi_data_out = oe ? cur_q.wdata : '0;
  assign bus.hpi_addr     = cur_q.addr;
  assign bus.req_ready    = !fifo_full;
  assign bus.busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rdata_q;
`ifdef HPI_RESET_SEQ_EN
  assign bus.hpi_reset_n  = (state_q != ST_RST);
`else
  assign bus.hpi_reset_n  = 1'b1;
`endif

endmodule
